// File: rtl/change_dispenser_if.sv
// Bundle of the change-request side and coin-hopper side signals of the change dispenser.
// The master side makes change requests and acknowledges coins; the slave side is the dispenser.
interface change_dispenser_if;
    logic       changeValid;
    logic [8:0] changeAmount;
    logic       coinAck;
    logic       busy;
    logic       reqDollar;
    logic       reqQuarter;
    logic       reqDime;
    logic       reqNickel;
    logic       changeDone;
    logic [2:0] residual;
    logic       errRange;
    logic [8:0] dispensedTotal;

    modport master (
        output changeValid, changeAmount, coinAck,
        input  busy, reqDollar, reqQuarter, reqDime, reqNickel,
               changeDone, residual, errRange, dispensedTotal
    );

    modport slave (
        input  changeValid, changeAmount, coinAck,
        output busy, reqDollar, reqQuarter, reqDime, reqNickel,
               changeDone, residual, errRange, dispensedTotal
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin dispenser: breaks a change amount into dollar/quarter/dime/nickel requests,
// one coin at a time, with a hopper acknowledge per coin and a guaranteed idle gap between coins.
module change_dispenser (
    input  logic                 clk,
    input  logic                 reset,
    change_dispenser_if.slave    bus
);

    typedef enum logic [2:0] {IDLE, SELECT, REQ, GAP, DONE} state_t;

    localparam logic [8:0] DOLLAR     = 9'd100;
    localparam logic [8:0] QUARTER    = 9'd25;
    localparam logic [8:0] DIME       = 9'd10;
    localparam logic [8:0] NICKEL     = 9'd5;
    localparam logic [8:0] MAX_AMOUNT = 9'd500;

    state_t     state;
    logic [8:0] remaining;
    logic [8:0] coinValue;

    assign bus.busy = (state != IDLE);

    // Coin choice only happens when remaining covers the coin, so the subtraction in REQ never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            remaining          <= '0;
            coinValue          <= '0;
            bus.reqDollar      <= 1'b0;
            bus.reqQuarter     <= 1'b0;
            bus.reqDime        <= 1'b0;
            bus.reqNickel      <= 1'b0;
            bus.changeDone     <= 1'b0;
            bus.errRange       <= 1'b0;
            bus.residual       <= '0;
            bus.dispensedTotal <= '0;
        end else begin
            bus.errRange   <= 1'b0;
            bus.changeDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.changeValid) begin
                        if (bus.changeAmount > MAX_AMOUNT) begin
                            bus.errRange <= 1'b1;
                        end else begin
                            remaining          <= bus.changeAmount;
                            bus.dispensedTotal <= '0;
                            state              <= SELECT;
                        end
                    end
                end
                SELECT: begin
                    if (remaining >= DOLLAR) begin
                        bus.reqDollar <= 1'b1;
                        coinValue     <= DOLLAR;
                        state         <= REQ;
                    end else if (remaining >= QUARTER) begin
                        bus.reqQuarter <= 1'b1;
                        coinValue      <= QUARTER;
                        state          <= REQ;
                    end else if (remaining >= DIME) begin
                        bus.reqDime <= 1'b1;
                        coinValue   <= DIME;
                        state       <= REQ;
                    end else if (remaining >= NICKEL) begin
                        bus.reqNickel <= 1'b1;
                        coinValue     <= NICKEL;
                        state         <= REQ;
                    end else begin
                        bus.changeDone <= 1'b1;
                        bus.residual   <= remaining[2:0];
                        state          <= DONE;
                    end
                end
                REQ: begin
                    if (bus.coinAck) begin
                        remaining          <= remaining - coinValue;
                        bus.dispensedTotal <= bus.dispensedTotal + coinValue;
                        bus.reqDollar      <= 1'b0;
                        bus.reqQuarter     <= 1'b0;
                        bus.reqDime        <= 1'b0;
                        bus.reqNickel      <= 1'b0;
                        state              <= GAP;
                    end
                end
                GAP: begin
                    state <= SELECT;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: each request pushes its expected coin sequence and
// completion record, and a monitor pops and compares them as the dispenser produces events.
module tb_change_dispenser;

    localparam int KIND_COIN = 0;
    localparam int KIND_DONE = 1;
    localparam int KIND_ERR  = 2;

    typedef struct {
        int kind;
        int value;
        int resid;
    } expEntry_t;

    logic clk = 1'b0;
    logic reset;
    change_dispenser_if bus ();

    change_dispenser dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    expEntry_t expQ[$];
    int vectors     = 0;
    int miscompares = 0;
    int doneCount   = 0;
    int ackDelay    = 2;
    bit hopperEnable = 1'b1;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int coinOf(input logic [3:0] reqs);
        case (reqs)
            4'b1000: return 100;
            4'b0100: return 25;
            4'b0010: return 10;
            4'b0001: return 5;
            default: return -1;
        endcase
    endfunction

    // Greedy reference: expected coins, then the completion record with total and leftover cents.
    task automatic applyStimulus(input int amount);
        int rem;
        int total;
        expEntry_t e;
        if (amount > 500) begin
            e = '{KIND_ERR, 0, 0};
            expQ.push_back(e);
        end else begin
            rem   = amount;
            total = 0;
            while (rem >= 5) begin
                if (rem >= 100)     e = '{KIND_COIN, 100, 0};
                else if (rem >= 25) e = '{KIND_COIN, 25, 0};
                else if (rem >= 10) e = '{KIND_COIN, 10, 0};
                else                e = '{KIND_COIN, 5, 0};
                expQ.push_back(e);
                rem   -= e.value;
                total += e.value;
            end
            e = '{KIND_DONE, total, rem};
            expQ.push_back(e);
        end
        strobeOnly(amount);
    endtask

    task automatic strobeOnly(input int amount);
        @(negedge clk);
        bus.changeValid  = 1'b1;
        bus.changeAmount = 9'(amount);
        @(negedge clk);
        bus.changeValid  = 1'b0;
        bus.changeAmount = '0;
    endtask

    task automatic waitDone(input int startCount, input int budget);
        int n = 0;
        while (doneCount == startCount && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("doneSeen", int'(doneCount != startCount), 1);
    endtask

    // Hopper model: acknowledges a held request after ackDelay low-phase samples.
    initial begin
        int reqAge = 0;
        bus.coinAck = 1'b0;
        forever begin
            @(negedge clk);
            if (hopperEnable && (bus.reqDollar || bus.reqQuarter || bus.reqDime || bus.reqNickel)) begin
                reqAge++;
                bus.coinAck = (reqAge == ackDelay);
            end else begin
                reqAge = 0;
                bus.coinAck = 1'b0;
            end
        end
    end

    initial begin
        logic prevAny = 1'b0;
        logic [3:0] reqs;
        expEntry_t e;
        forever begin
            @(negedge clk);
            reqs = {bus.reqDollar, bus.reqQuarter, bus.reqDime, bus.reqNickel};
            if (!reset && (reqs != 4'b0) && !prevAny) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedCoin", coinOf(reqs), 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("coinKind", KIND_COIN, e.kind);
                    checkOutput("coinValue", coinOf(reqs), e.value);
                end
            end
            prevAny = (reqs != 4'b0);
            if (!reset && bus.changeDone) begin
                doneCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedDone", int'(bus.dispensedTotal), -1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("doneKind", KIND_DONE, e.kind);
                    checkOutput("doneTotal", int'(bus.dispensedTotal), e.value);
                    checkOutput("doneResidual", int'(bus.residual), e.resid);
                    checkOutput("doneBusy", int'(bus.busy), 1);
                end
            end
            if (!reset && bus.errRange) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedErr", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("errKind", KIND_ERR, e.kind);
                    checkOutput("errBusy", int'(bus.busy), 0);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start;
        int found;
        bus.changeValid  = 1'b0;
        bus.changeAmount = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rstBusy", int'(bus.busy), 0);
        checkOutput("rstReqs", int'({bus.reqDollar, bus.reqQuarter, bus.reqDime, bus.reqNickel}), 0);
        checkOutput("rstTotal", int'(bus.dispensedTotal), 0);
        checkOutput("rstResidual", int'(bus.residual), 0);
        reset = 1'b0;
        $display("[TB] reset released");

        start = doneCount;
        applyStimulus(65);
        @(negedge clk);
        #1;
        checkOutput("latency65", int'(bus.reqQuarter), 1);
        waitDone(start, 200);

        start = doneCount;
        applyStimulus(500);
        waitDone(start, 400);

        applyStimulus(501);
        #1;
        checkOutput("rejectBusy", int'(bus.busy), 0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rejectTotalKept", int'(bus.dispensedTotal), 500);
        checkOutput("rejectIdle", int'(bus.busy), 0);

        start = doneCount;
        applyStimulus(0);
        @(negedge clk);
        #1;
        checkOutput("latencyZero", int'(bus.changeDone), 1);
        waitDone(start, 20);

        start = doneCount;
        applyStimulus(3);
        waitDone(start, 20);

        start = doneCount;
        applyStimulus(140);
        repeat (3) @(negedge clk);
        strobeOnly(5);
        waitDone(start, 300);

        hopperEnable = 1'b0;
        expQ.push_back('{KIND_COIN, 25, 0});
        strobeOnly(30);
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clk);
            #1;
            if (bus.reqQuarter) found = 1;
        end
        checkOutput("quarterPending", found, 1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("midRstReqs", int'({bus.reqDollar, bus.reqQuarter, bus.reqDime, bus.reqNickel}), 0);
        checkOutput("midRstBusy", int'(bus.busy), 0);
        checkOutput("midRstDone", int'(bus.changeDone), 0);
        checkOutput("midRstErr", int'(bus.errRange), 0);
        checkOutput("midRstTotal", int'(bus.dispensedTotal), 0);
        checkOutput("midRstResidual", int'(bus.residual), 0);
        reset = 1'b0;
        hopperEnable = 1'b1;

        start = doneCount;
        applyStimulus(10);
        waitDone(start, 50);

        repeat (4) @(negedge clk);
        checkOutput("queueDrained", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
